// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - default address / instruction widths
//   - fetch FSM state encoding
//   - fetch_busy(): true while a memory request is outstanding
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 16;
  localparam int unsigned FETCH_INST_W = 16;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  // A request is outstanding in every state except IDLE.
  function automatic logic fetch_busy(input fetch_state_e s);
    return s != FETCH_IDLE;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Two-entry FIFO of fetched {inst, pc} entries, used by fetch_unit when
// FETCH_PREFETCH_EN is defined.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   flush_i           - drop all entries (wins over push/pop)
//   push_i, push_data_i - write one entry
//   pop_i             - remove the head entry
//   valid_o           - FIFO non-empty
//   full_o            - both entries occupied
//   head_o            - oldest entry (driven straight from a register)
module inst_queue #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic              full_o,
  output logic [DATA_W-1:0] head_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              do_push, do_pop;

  // Shift-style storage: the head slot is always the output register.
  always_comb begin
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = push_data_i;
          else               tail_d = push_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_d = push_data_i;
          end else begin
            head_d = tail_q;
            tail_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign valid_o = cnt_q != 2'd0;
  assign full_o  = cnt_q == 2'd2;
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the architectural PC, issues one
// instruction-memory read at a time over req/ack, and hands fetched
// instructions to decode over valid/ready. The PC increment / branch target
// comes from an external PC_Adder through next_pc.
// Build option: FETCH_PREFETCH_EN selects a 2-entry output FIFO
// (inst_queue); otherwise a single output register is used.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   pc / next_pc              - PC register out, PC_Adder result in
//   halt, redirect            - stop new fetches / branch taken this cycle
//   imem_req, imem_addr       - memory request (req decoded from state)
//   imem_ack, imem_rdata      - memory completion and data
//   inst_valid, inst_out, inst_pc, inst_ready - decode handshake
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned                INST_ADDR_WIDTH = FETCH_ADDR_W,
  parameter int unsigned                INST_WIDTH      = FETCH_INST_W,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [INST_ADDR_WIDTH-1:0] pc,
  input  logic [INST_ADDR_WIDTH-1:0] next_pc,
  input  logic                       halt,
  input  logic                       redirect,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [INST_WIDTH-1:0]      imem_rdata,
  output logic                       inst_valid,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [INST_ADDR_WIDTH-1:0] inst_pc,
  input  logic                       inst_ready
);

  fetch_state_e                 state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                         push_c, flush_c, pop_c, space_c;

  assign pop_c = inst_valid && inst_ready;

  // Next-state logic. A redirect flushes the output buffer in every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push_c  = 1'b0;
    flush_c = redirect;
    case (state_q)
      FETCH_IDLE: begin
        if (redirect) begin
          pc_d = next_pc;
        end else if (!halt && space_c) begin
          addr_d  = pc_q;
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_ack) begin
          // Data arriving together with a redirect belongs to the old path.
          pc_d    = next_pc;
          push_c  = !redirect;
          state_d = FETCH_IDLE;
        end else if (redirect) begin
          pc_d    = next_pc;
          state_d = FETCH_DROP;
        end
      end
      FETCH_DROP: begin
        if (redirect) pc_d = next_pc;
        if (imem_ack) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = addr_q;
  assign imem_req  = fetch_busy(state_q);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned EntryW = INST_WIDTH + INST_ADDR_WIDTH;

  logic [EntryW-1:0] head;
  logic              full;

  inst_queue #(
    .DATA_W (EntryW)
  ) u_inst_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_c),
    .push_i      (push_c),
    .push_data_i ({imem_rdata, addr_q}),
    .pop_i       (pop_c),
    .valid_o     (inst_valid),
    .full_o      (full),
    .head_o      (head)
  );

  // An entry leaving this cycle frees a slot for the next issue.
  assign space_c = !full || pop_c;
  assign {inst_out, inst_pc} = head;
`else
  logic                       valid_q, valid_d;
  logic [INST_WIDTH-1:0]      inst_q, inst_d;
  logic [INST_ADDR_WIDTH-1:0] ipc_q, ipc_d;

  // Single output register; a push only ever lands while it is empty.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    if (flush_c) begin
      valid_d = 1'b0;
    end else if (push_c) begin
      valid_d = 1'b1;
      inst_d  = imem_rdata;
      ipc_d   = addr_q;
    end else if (pop_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  assign space_c    = !valid_q || pop_c;
  assign inst_valid = valid_q;
  assign inst_out   = inst_q;
  assign inst_pc    = ipc_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes the expected
// {inst, pc} pairs; a monitor pops and compares on every decode handshake.
// Memory returns ~addr as instruction data; PC_Adder is modelled inline.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic        halt;
  logic        redirect;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic        inst_ready;

  logic [15:0] target;
  int          ack_delay;
  int          checks;
  int          failures;
  logic [31:0] exp_q[$];

  fetch_unit #(
    .INST_ADDR_WIDTH (16),
    .INST_WIDTH      (16),
    .RESET_PC        (16'h0100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .next_pc    (next_pc),
    .halt       (halt),
    .redirect   (redirect),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC_Adder: branch target on redirect, hold on halt, else +2 (wrapping).
  always_comb begin
    if (redirect)  next_pc = target;
    else if (halt) next_pc = pc;
    else           next_pc = 16'(pc + 16'd2);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [15:0] a, input logic [15:0] inst);
    exp_q.push_back({inst, a});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for n memory acks (bounded), return on the following negedge.
  task automatic wait_acks(input int n, input string name);
    int got = 0;
    int cnt = 0;
    while (got < n && cnt < 200) begin
      @(posedge clk);
      if (imem_ack) got++;
      cnt++;
    end
    chk(name, 16'(got), 16'(n));
    @(negedge clk);
  endtask

  // Memory: ack after ack_delay extra request cycles, data = ~addr.
  initial begin
    int req_cnt;
    req_cnt    = 0;
    imem_ack   = 1'b0;
    imem_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !imem_req || imem_ack) begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        req_cnt    = 0;
      end else begin
        req_cnt++;
        if (req_cnt > ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = ~imem_addr;
        end
      end
    end
  end

  // Monitor: every accepted instruction must match the next expected entry.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got pc=%h inst=%h required no instruction", inst_pc, inst_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", inst_pc, e[15:0]);
          chk("sb_inst", inst_out, e[31:16]);
        end
      end
    end
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    halt       = 1'b0;
    redirect   = 1'b0;
    target     = 16'h0000;
    inst_ready = 1'b1;
    ack_delay  = 0;
    cyc(3);

    // Reset state
    chk("rst_pc", pc, 16'h0100);
    chk("rst_req", 16'(imem_req), 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", 16'(inst_valid), 16'd0);
    chk("rst_inst", inst_out, 16'h0000);
    chk("rst_ipc", inst_pc, 16'h0000);

    // Sequential fetch from RESET_PC
    exp_push(16'h0100, 16'hFEFF);
    exp_push(16'h0102, 16'hFEFD);
    exp_push(16'h0104, 16'hFEFB);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", 16'(imem_req), 16'd1);
    chk("first_addr", imem_addr, 16'h0100);
    wait_acks(3, "seq_acks");
    halt = 1'b1;
    cyc(3);

    // Backpressure: entries held, no further requests, order kept
    inst_ready = 1'b0;
    exp_push(16'h0106, 16'hFEF9);
`ifdef FETCH_PREFETCH_EN
    exp_push(16'h0108, 16'hFEF7);
`endif
    halt = 1'b0;
    cyc(10);
    chk("bp_req", 16'(imem_req), 16'd0);
    chk("bp_valid", 16'(inst_valid), 16'd1);
    chk("bp_head_pc", inst_pc, 16'h0106);
    halt       = 1'b1;
    inst_ready = 1'b1;
    cyc(4);

    // Redirect in IDLE flushes a held instruction
    inst_ready = 1'b0;
    halt       = 1'b0;
    wait_acks(1, "flush_ack");
    halt     = 1'b1;
    redirect = 1'b1;
    target   = 16'h0300;
    @(negedge clk);
    redirect = 1'b0;
    chk("flush_valid", 16'(inst_valid), 16'd0);
    chk("flush_pc", pc, 16'h0300);
    inst_ready = 1'b1;
    cyc(2);

    // Redirect during WAIT with ack delayed: data dropped, refetch target
    ack_delay = 3;
    halt      = 1'b0;
    @(negedge clk);
    chk("wait_req", 16'(imem_req), 16'd1);
    redirect = 1'b1;
    target   = 16'h0200;
    @(negedge clk);
    redirect = 1'b0;
    chk("drop_pc", pc, 16'h0200);
    chk("drop_req", 16'(imem_req), 16'd1);
    chk("drop_valid", 16'(inst_valid), 16'd0);
    exp_push(16'h0200, 16'hFDFF);
    cyc(3);
    chk("drop_done_req", 16'(imem_req), 16'd0);
    chk("drop_done_pc", pc, 16'h0200);
    @(negedge clk);
    chk("refetch_req", 16'(imem_req), 16'd1);
    chk("refetch_addr", imem_addr, 16'h0200);
    wait_acks(1, "refetch_ack");
    halt = 1'b1;
    cyc(3);

    // Redirect coinciding with ack: data dropped, no DROP state
    ack_delay = 2;
    halt      = 1'b0;
    cyc(3);
    chk("coinc_req", 16'(imem_req), 16'd1);
    redirect = 1'b1;
    target   = 16'h0400;
    halt     = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    chk("coinc_req_low", 16'(imem_req), 16'd0);
    chk("coinc_pc", pc, 16'h0400);
    chk("coinc_valid", 16'(inst_valid), 16'd0);
    cyc(2);

    // Halt mid-WAIT: in-flight fetch delivered, PC held, no new request
    exp_push(16'h0400, 16'hFBFF);
    halt = 1'b0;
    @(negedge clk);
    chk("halt_wait_req", 16'(imem_req), 16'd1);
    halt = 1'b1;
    cyc(3);
    chk("halt_pc", pc, 16'h0400);
    cyc(4);
    chk("halt_no_req", 16'(imem_req), 16'd0);
    chk("halt_pc_still", pc, 16'h0400);

    // PC wrap 0xFFFE -> 0x0000
    redirect = 1'b1;
    target   = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_start_pc", pc, 16'hFFFE);
    exp_push(16'hFFFE, 16'h0001);
    exp_push(16'h0000, 16'hFFFF);
    ack_delay = 0;
    halt      = 1'b0;
    wait_acks(2, "wrap_acks");
    halt = 1'b1;
    chk("wrap_end_pc", pc, 16'h0002);
    cyc(3);

    // Reset during DROP
    ack_delay = 3;
    halt      = 1'b0;
    @(negedge clk);
    chk("rdrop_req", 16'(imem_req), 16'd1);
    redirect = 1'b1;
    target   = 16'h0500;
    halt     = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    chk("rdrop_in_drop", 16'(imem_req), 16'd1);
    chk("rdrop_pc", pc, 16'h0500);
    rst = 1'b1;
    @(negedge clk);
    chk("rdrop_rst_req", 16'(imem_req), 16'd0);
    chk("rdrop_rst_pc", pc, 16'h0100);
    chk("rdrop_rst_valid", 16'(inst_valid), 16'd0);
    rst = 1'b0;
    cyc(4);
    chk("rdrop_idle_req", 16'(imem_req), 16'd0);

    cyc(2);
    chk("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
